// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Sequences one MULT or DIV on the shared multiply/divide unit and commits
//   the result into the HI/LO register pair. The control unit stalls on busy
//   and does not count cycles itself.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for op_req; latches op_sel and loads the counter
//   LAUNCH | one-cycle start pulse to the selected unit
//   WAIT   | counts down the unit latency; a DIV may abort on divzero
//   COMMIT | HI/LO load enables and done pulse
//   EXC    | divide-by-zero pulse; HI/LO keep their old contents
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   op_req, op_sel       one-cycle request (op_sel 1 = MULT, 0 = DIV)
//   divzero              divide-by-zero flag from the divider
//   busy                 high in every state except IDLE
//   mult_start/div_start one-cycle unit start pulses
//   HiLoSrc              HI/LO source mux select (the accepted op_sel)
//   HI_write/LO_write    HI/LO load enables
//   done, div_by_zero    completion / exception pulses
module muldiv_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic op_req,
  input  logic op_sel,
  input  logic divzero,
  output logic busy,
  output logic mult_start,
  output logic div_start,
  output logic HiLoSrc,
  output logic HI_write,
  output logic LO_write,
  output logic done,
  output logic div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_COMMIT,
    S_EXC
  } state_t;

  localparam logic [5:0] MULT_N = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_N  = 6'(DIV_CYCLES);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       op_q, op_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    busy        = 1'b0;
    mult_start  = 1'b0;
    div_start   = 1'b0;
    HI_write    = 1'b0;
    LO_write    = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_req) begin
          state_d = S_LAUNCH;
          op_d    = op_sel;
          cnt_d   = op_sel ? MULT_N : DIV_N;
        end
      end
      S_LAUNCH: begin
        busy       = 1'b1;
        mult_start = op_q;
        div_start  = !op_q;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q - 6'd1;
        // Divide-by-zero wins over the final latency cycle; the counter
        // leaves WAIT at 1 so it never wraps.
        if (!op_q && divzero) begin
          state_d = S_EXC;
        end else if (cnt_q == 6'd1) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        busy     = 1'b1;
        HI_write = 1'b1;
        LO_write = 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      S_EXC: begin
        busy        = 1'b1;
        div_by_zero = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holds the last accepted selection, including while idle.
  assign HiLoSrc = op_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst = 2'b11, req = 2'b00, sel = 2'b00, dz = 2'b00;
  logic [1:0] busy_w, ms_w, ds_w, hls_w, hw_w, lw_w, done_w, dbz_w;

  muldiv_sequencer dut_a (
    .clk(clk), .reset(rst[0]), .op_req(req[0]), .op_sel(sel[0]), .divzero(dz[0]),
    .busy(busy_w[0]), .mult_start(ms_w[0]), .div_start(ds_w[0]), .HiLoSrc(hls_w[0]),
    .HI_write(hw_w[0]), .LO_write(lw_w[0]), .done(done_w[0]), .div_by_zero(dbz_w[0]));

  muldiv_sequencer #(.MULT_CYCLES(1), .DIV_CYCLES(5)) dut_b (
    .clk(clk), .reset(rst[1]), .op_req(req[1]), .op_sel(sel[1]), .divzero(dz[1]),
    .busy(busy_w[1]), .mult_start(ms_w[1]), .div_start(ds_w[1]), .HiLoSrc(hls_w[1]),
    .HI_write(hw_w[1]), .LO_write(lw_w[1]), .done(done_w[1]), .div_by_zero(dbz_w[1]));

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  // Reference model: an operation is tracked by its age in cycles since the
  // accepting edge. Age 1 is the start pulse, ages 2..N+1 are the latency
  // window, age N+2 is the commit cycle. exc_m marks the exception cycle.
  int mult_n[2] = '{32, 1};
  int div_n[2]  = '{32, 5};
  int age[2]    = '{0, 0};
  int n_m[2]    = '{0, 0};
  bit op_m[2]   = '{0, 0};
  bit exc_m[2]  = '{0, 0};
  bit hilo_m[2] = '{0, 0};

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    if (rst[i]) begin
      age[i] = 0; exc_m[i] = 0; hilo_m[i] = 0;
    end else if (exc_m[i]) begin
      exc_m[i] = 0;
    end else if (age[i] == 0) begin
      if (req[i]) begin
        age[i] = 1; op_m[i] = sel[i]; hilo_m[i] = sel[i];
        n_m[i] = sel[i] ? mult_n[i] : div_n[i];
      end
    end else if (age[i] >= 2 && age[i] <= n_m[i] + 1 && !op_m[i] && dz[i]) begin
      age[i] = 0; exc_m[i] = 1;
    end else if (age[i] == n_m[i] + 2) begin
      age[i] = 0;
    end else begin
      age[i]++;
    end
  endtask

  function automatic logic [7:0] exp_vec(input int i);
    bit c;
    c = (age[i] != 0) && (age[i] == n_m[i] + 2);
    return {(age[i] != 0) || exc_m[i], age[i] == 1 && op_m[i], age[i] == 1 && !op_m[i],
            hilo_m[i], c, c, c, exc_m[i]};
  endfunction

  function automatic logic [7:0] out_vec(input int i);
    return {busy_w[i], ms_w[i], ds_w[i], hls_w[i], hw_w[i], lw_w[i], done_w[i], dbz_w[i]};
  endfunction

  // Cycle-by-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      model_step(0);
      model_step(1);
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (out_vec(i) !== exp_vec(i)) begin
          miscompares++;
          $display("FAIL outputs dut%0d edge %0d: got %b, expected %b (busy,ms,ds,hls,hw,lw,done,dbz)",
                   i, edge_n, out_vec(i), exp_vec(i));
        end
      end
    end
  end

  // Issue one request at the current negedge and follow it until busy drops.
  // Cycle k is the interval after the k-th edge following the accepting edge.
  task automatic run_op(input int i, input bit s, input int dz_k, input int rq1, input int rq2,
                        input int rst_k, output int done_k, output int exc_k, output int busy_n,
                        output int done_cnt, output int done_abs);
    done_k = 0; exc_k = 0; busy_n = 0; done_cnt = 0; done_abs = 0;
    req[i] = 1'b1; sel[i] = s;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (busy_w[i] !== 1'b1) begin
        req[i] = 1'b0; dz[i] = 1'b0; rst[i] = 1'b0;
        if (k == 1) chk("busy after accept", 0, 1);
        return;
      end
      busy_n++;
      if (done_w[i] === 1'b1) begin
        done_cnt++;
        if (done_k == 0) begin done_k = k; done_abs = edge_n; end
      end
      if (dbz_w[i] === 1'b1 && exc_k == 0) exc_k = k;
      req[i] = (k == rq1) || (k == rq2);
      dz[i]  = (k == dz_k);
      rst[i] = (k == rst_k);
    end
    chk("busy timeout", 1, 0);
    req[i] = 1'b0; dz[i] = 1'b0; rst[i] = 1'b0;
  endtask

  typedef struct {
    int dut;
    bit sel;
    int dz_k;
    int exp_done;
    int exp_exc;
    int exp_busy;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int d, e, b, dc, da, da_prev;

    tbl[0]  = '{0, 1'b1, 0,  34, 0,  34};
    tbl[1]  = '{0, 1'b0, 0,  34, 0,  34};
    tbl[2]  = '{0, 1'b0, 4,  0,  5,  5};
    tbl[3]  = '{0, 1'b1, 4,  34, 0,  34};
    tbl[4]  = '{0, 1'b0, 2,  0,  3,  3};
    tbl[5]  = '{0, 1'b0, 33, 0,  34, 34};
    tbl[6]  = '{0, 1'b0, 1,  34, 0,  34};
    tbl[7]  = '{1, 1'b1, 0,  3,  0,  3};
    tbl[8]  = '{1, 1'b0, 0,  7,  0,  7};
    tbl[9]  = '{1, 1'b0, 6,  0,  7,  7};
    tbl[10] = '{1, 1'b0, 7,  7,  0,  7};

    repeat (3) @(negedge clk);
    rst = 2'b00;
    chk("reset outputs dut0", out_vec(0), 0);
    chk("reset outputs dut1", out_vec(1), 0);
    @(negedge clk);

    foreach (tbl[t]) begin
      run_op(tbl[t].dut, tbl[t].sel, tbl[t].dz_k, 0, 0, 0, d, e, b, dc, da);
      chk($sformatf("vec%0d done cycle", t), d, tbl[t].exp_done);
      chk($sformatf("vec%0d exc cycle", t), e, tbl[t].exp_exc);
      chk($sformatf("vec%0d busy cycles", t), b, tbl[t].exp_busy);
      chk($sformatf("vec%0d done count", t), dc, (tbl[t].exp_done != 0) ? 1 : 0);
    end

    // Requests during a MULT are dropped, including the one in COMMIT.
    run_op(0, 1'b1, 0, 10, 34, 0, d, e, b, dc, da);
    chk("busy req done cycle", d, 34);
    chk("busy req done count", dc, 1);
    chk("busy req busy cycles", b, 34);
    @(negedge clk);
    chk("busy req not queued", busy_w[0], 0);
    run_op(0, 1'b0, 0, 0, 0, 0, d, e, b, dc, da);
    chk("fresh div after ignored req", d, 34);

    // Reset in WAIT cycle 15 (cycle 16 overall).
    run_op(0, 1'b1, 0, 0, 0, 16, d, e, b, dc, da);
    chk("mid reset busy cycles", b, 16);
    chk("mid reset no done", dc, 0);
    chk("mid reset outputs", out_vec(0), 0);
    run_op(0, 1'b0, 0, 0, 0, 0, d, e, b, dc, da);
    chk("div after reset done", d, 34);

    // Back-to-back MULTs on the short instance: one every 4 cycles.
    run_op(1, 1'b1, 0, 0, 0, 0, d, e, b, dc, da_prev);
    for (int r = 0; r < 3; r++) begin
      run_op(1, 1'b1, 0, 0, 0, 0, d, e, b, dc, da);
      chk("back-to-back period", da - da_prev, 4);
      da_prev = da;
    end

    // Random operations; the per-cycle model does the checking.
    for (int r = 0; r < 60; r++) begin
      int i, dzk, rq, rk;
      i   = $urandom_range(0, 1);
      dzk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 36) : 0;
      rq  = $urandom_range(0, 36);
      rk  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 35) : 0;
      run_op(i, 1'($urandom_range(0, 1)), dzk, rq, 0, rk, d, e, b, dc, da);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
